pixel_word_unpacker: RTL and testbench

//   Display-side counterpart of the bench pixel capture: accepts packed 32-bit words of
//   2-bit pixels over a valid/ready stream and emits one pixel per clock while the VGA

---
 rtl/pixel_word_unpacker.sv | 97 +++++++++
 tb/tb_pixel_word_unpacker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_word_unpacker.sv
// Unpacks 32-bit words of 2-bit pixels (MSB first) into one pixel per clock inside the sprite window.
// Latency: o_Pixel/o_Pixel_Valid registered one cycle after the raster position is presented.
// Backpressure: one hold word plus one shift word; o_Word_Ready drops while hold is occupied or on frame start.
module pixel_word_unpacker #(
   parameter int WIN_X0 = 16,
   parameter int WIN_W  = 256,
   parameter int WIN_Y0 = 0,
   parameter int WIN_H  = 256
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Frame_Start,
   input  logic [9:0]  i_Row,
   input  logic [9:0]  i_Column,
   input  logic [31:0] i_Word_Data,
   input  logic        i_Word_Valid,
   output logic        o_Word_Ready,
   output logic [1:0]  o_Pixel,
   output logic        o_Pixel_Valid,
   output logic        o_Underrun,
   output logic [15:0] o_Word_Count
);

   logic [31:0] hold_dat;
   logic [31:0] sr_dat;
   logic        hold_full;
   logic        sr_full;
   logic [3:0]  pix_idx;

   logic [9:0]  row_off;
   logic [9:0]  col_off;
   logic        in_win;
   logic        accept;
   logic        shift_en;
   logic        last_pix;
   logic        hold_take;

   // Unsigned wrap makes positions left of / above the window compare as out of range.
   assign row_off = i_Row - 10'(WIN_Y0);
   assign col_off = i_Column - 10'(WIN_X0);
   assign in_win  = (row_off < 10'(WIN_H)) && (col_off < 10'(WIN_W));

   assign o_Word_Ready = !hold_full && !i_Frame_Start;
   assign accept       = i_Word_Valid && o_Word_Ready;
   assign shift_en     = in_win && sr_full;
   assign last_pix     = shift_en && (pix_idx == 4'd15);
   // Hold moves to the shifter when the shifter is empty or finishing its last pixel.
   assign hold_take    = hold_full && (!sr_full || last_pix);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         hold_dat      <= '0;
         sr_dat        <= '0;
         hold_full     <= 1'b0;
         sr_full       <= 1'b0;
         pix_idx       <= '0;
         o_Pixel       <= 2'b00;
         o_Pixel_Valid <= 1'b0;
         o_Underrun    <= 1'b0;
         o_Word_Count  <= '0;
      end else if (i_Frame_Start) begin
         hold_full     <= 1'b0;
         sr_full       <= 1'b0;
         pix_idx       <= '0;
         o_Pixel       <= 2'b00;
         o_Pixel_Valid <= 1'b0;
         o_Word_Count  <= '0;
      end else begin
         if (accept) begin
            hold_dat  <= i_Word_Data;
            hold_full <= 1'b1;
         end else if (hold_take) begin
            hold_full <= 1'b0;
         end

         o_Pixel       <= shift_en ? sr_dat[31:30] : 2'b00;
         o_Pixel_Valid <= in_win;
         if (in_win && !sr_full)
            o_Underrun <= 1'b1;

         if (hold_take) begin
            sr_dat  <= hold_dat;
            sr_full <= 1'b1;
            pix_idx <= '0;
         end else if (shift_en) begin
            sr_dat  <= sr_dat << 2;
            pix_idx <= pix_idx + 4'd1;
            if (last_pix)
               sr_full <= 1'b0;
         end

         if (last_pix)
            o_Word_Count <= o_Word_Count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Directed bench for pixel_word_unpacker: hand-computed pixel streams, window edges, underrun,
// backpressure, frame flush and a full-frame word round trip.
module tb_pixel_word_unpacker;

   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic        i_Frame_Start;
   logic [9:0]  i_Row;
   logic [9:0]  i_Column;
   logic [31:0] i_Word_Data;
   logic        i_Word_Valid;
   logic        o_Word_Ready;
   logic [1:0]  o_Pixel;
   logic        o_Pixel_Valid;
   logic        o_Underrun;
   logic [15:0] o_Word_Count;

   int total = 0;
   int bad   = 0;
   logic [31:0] prod_q[$];

   always #5 i_Clk = ~i_Clk;

   pixel_word_unpacker dut (
      .i_Clk         (i_Clk),
      .i_Reset       (i_Reset),
      .i_Frame_Start (i_Frame_Start),
      .i_Row         (i_Row),
      .i_Column      (i_Column),
      .i_Word_Data   (i_Word_Data),
      .i_Word_Valid  (i_Word_Valid),
      .o_Word_Ready  (o_Word_Ready),
      .o_Pixel       (o_Pixel),
      .o_Pixel_Valid (o_Pixel_Valid),
      .o_Underrun    (o_Underrun),
      .o_Word_Count  (o_Word_Count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_prod();
      if (prod_q.size() > 0) begin
         i_Word_Valid = 1'b1;
         i_Word_Data  = prod_q[0];
      end else begin
         i_Word_Valid = 1'b0;
         i_Word_Data  = '0;
      end
   endtask

   // One clock: settle, note whether the producer's word transfers, clock, sample point.
   task automatic tick();
      logic xfer;
      #1;
      xfer = i_Word_Valid && o_Word_Ready;
      @(posedge i_Clk);
      #1;
      if (xfer)
         void'(prod_q.pop_front());
      drive_prod();
   endtask

   task automatic set_rc(input int r, input int c);
      i_Row    = 10'(r);
      i_Column = 10'(c);
   endtask

   function automatic logic [1:0] pat_e4(input int i);
      return 2'(3 - (i % 4));
   endfunction

   function automatic logic [1:0] pat_6c(input int i);
      return 2'((i + 1) % 4);
   endfunction

   initial begin
      logic [31:0] cap;
      logic [31:0] w0;
      int          npx;

      i_Reset = 1'b1; i_Frame_Start = 1'b0;
      i_Word_Valid = 1'b0; i_Word_Data = '0;
      set_rc(0, 0);

      // Reset
      repeat (3) tick();
      check("rst_pixel", 32'(o_Pixel), 32'd0);
      check("rst_pvld", 32'(o_Pixel_Valid), 32'd0);
      check("rst_underrun", 32'(o_Underrun), 32'd0);
      check("rst_count", 32'(o_Word_Count), 32'd0);
      i_Reset = 1'b0;
      tick();
      check("rst_ready", 32'(o_Word_Ready), 32'd1);

      // Preload 0xE4E4E4E4 and sweep 16 columns
      prod_q.push_back(32'hE4E4_E4E4);
      drive_prod();
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         set_rc(0, 16 + i);
         tick();
         check("e4_pixel", 32'(o_Pixel), 32'(pat_e4(i)));
         check("e4_pvld", 32'(o_Pixel_Valid), 32'd1);
      end
      check("e4_count", 32'(o_Word_Count), 32'd1);
      set_rc(0, 0);
      tick();
      check("e4_out_pvld", 32'(o_Pixel_Valid), 32'd0);
      check("e4_underrun", 32'(o_Underrun), 32'd0);

      // Out-of-window positions must not consume pixels
      prod_q.push_back(32'h6C6C_6C6C);
      drive_prod();
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         set_rc(0, 16 + i);
         tick();
         check("6c_pixel_a", 32'(o_Pixel), 32'(pat_6c(i)));
      end
      set_rc(0, 15);
      tick();
      check("col15_pvld", 32'(o_Pixel_Valid), 32'd0);
      check("col15_pixel", 32'(o_Pixel), 32'd0);
      set_rc(0, 272);
      tick();
      check("col272_pvld", 32'(o_Pixel_Valid), 32'd0);
      set_rc(256, 20);
      tick();
      check("row256_pvld", 32'(o_Pixel_Valid), 32'd0);
      for (int i = 2; i < 16; i++) begin
         set_rc(1, 16 + i);
         tick();
         check("6c_pixel_b", 32'(o_Pixel), 32'(pat_6c(i)));
      end
      check("6c_count", 32'(o_Word_Count), 32'd2);

      // Underrun with no data available
      set_rc(0, 16);
      tick();
      check("ur_pixel", 32'(o_Pixel), 32'd0);
      check("ur_pvld", 32'(o_Pixel_Valid), 32'd1);
      check("ur_flag", 32'(o_Underrun), 32'd1);
      set_rc(0, 0);
      tick();
      check("ur_sticky", 32'(o_Underrun), 32'd1);
      check("ur_count", 32'(o_Word_Count), 32'd2);

      // Backpressure: second word waits while hold is occupied
      prod_q.push_back(32'h0F0F_0F0F);
      prod_q.push_back(32'h1234_5678);
      drive_prod();
      tick();
      #1;
      check("busy_ready", 32'(o_Word_Ready), 32'd0);
      tick();
      tick();
      check("busy_q_empty", 32'(prod_q.size()), 32'd0);
      cap = '0;
      for (int i = 0; i < 32; i++) begin
         set_rc(2, 16 + i);
         tick();
         cap = {cap[29:0], o_Pixel};
         if (i == 15) check("busy_word0", cap, 32'h0F0F_0F0F);
      end
      check("busy_word1", cap, 32'h1234_5678);
      check("busy_count", 32'(o_Word_Count), 32'd4);

      // Frame start mid-word flushes everything except the underrun flag
      prod_q.push_back(32'hFFFF_FFFF);
      drive_prod();
      set_rc(0, 0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         set_rc(3, 16 + i);
         tick();
      end
      check("fs_pre_pixel", 32'(o_Pixel), 32'd3);
      i_Frame_Start = 1'b1;
      set_rc(3, 21);
      #1;
      check("fs_ready", 32'(o_Word_Ready), 32'd0);
      tick();
      i_Frame_Start = 1'b0;
      check("fs_pvld", 32'(o_Pixel_Valid), 32'd0);
      check("fs_pixel", 32'(o_Pixel), 32'd0);
      check("fs_count", 32'(o_Word_Count), 32'd0);
      check("fs_underrun", 32'(o_Underrun), 32'd1);
      set_rc(3, 22);
      tick();
      check("fs_flushed_pixel", 32'(o_Pixel), 32'd0);
      check("fs_flushed_pvld", 32'(o_Pixel_Valid), 32'd1);

      // Full frame round trip after a fresh reset and frame start
      set_rc(300, 0);
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      check("frame_rst_underrun", 32'(o_Underrun), 32'd0);
      i_Frame_Start = 1'b1;
      tick();
      i_Frame_Start = 1'b0;
      for (int k = 0; k < 4096; k++) prod_q.push_back(32'(k));
      drive_prod();
      cap = '0;
      npx = 0;
      for (int r = 0; r < 256; r++) begin
         for (int c = 0; c < 276; c++) begin
            set_rc(r, c);
            tick();
            if (o_Pixel_Valid) begin
               cap = {cap[29:0], o_Pixel};
               npx++;
               if (npx % 16 == 0) begin
                  w0 = 32'(npx / 16 - 1);
                  check("frame_word", cap, w0);
               end
            end
         end
      end
      check("frame_pixels", 32'(npx), 32'd65536);
      check("frame_count", 32'(o_Word_Count), 32'd4096);
      check("frame_underrun", 32'(o_Underrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
